cmsdk_mcu_ahb_arbiter: RTL

Three-master AHB-Lite bus arbiter for the dual-core MCU. CPU1, CPU2 and the DMA engine share the single system AHB bus whose address is decoded into the flash, DMA, SDRAM, APB, CPU2-mailbox and default-slave selects. The block grants one master at a time, re-arbitrating only at transfer boundaries. It drives the master index used by the address-phase mux (`hmaster`) and by the data-phase/response mux (`hmaster_d`).

---
 rtl/cmsdk_mcu_bus_pkg.sv | 49 ++++
 rtl/cmsdk_mcu_rr_pick.sv | 41 ++++
 rtl/cmsdk_mcu_ahb_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cmsdk_mcu_bus_pkg.sv
// Shared system-bus definitions for the dual-core MCU.
// Master indices, HTRANS codes and arbiter state encoding.
package cmsdk_mcu_bus_pkg;

  localparam logic [1:0] MST_CPU1 = 2'd0;
  localparam logic [1:0] MST_CPU2 = 2'd1;
  localparam logic [1:0] MST_DMA  = 2'd2;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  typedef enum logic {
    ST_PARK = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  function automatic logic [1:0] mst_next(input logic [1:0] m);
    logic [1:0] n;
    case (m)
      MST_CPU1: n = MST_CPU2;
      MST_CPU2: n = MST_DMA;
      default:  n = MST_CPU1;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] mst_oh(input logic [1:0] m);
    logic [2:0] oh;
    case (m)
      MST_CPU2: oh = 3'b010;
      MST_DMA:  oh = 3'b100;
      default:  oh = 3'b001;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] mst_idx(input logic [2:0] oh);
    logic [1:0] m;
    unique case (1'b1)
      oh[1]:   m = MST_CPU2;
      oh[2]:   m = MST_DMA;
      default: m = MST_CPU1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cmsdk_mcu_rr_pick.sv
// Three-way round-robin picker; masked requesters only win
// when no unmasked requester is present.
module cmsdk_mcu_rr_pick
  import cmsdk_mcu_bus_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] start,
  input  logic [2:0] mask,
  output logic [2:0] win,
  output logic       valid
);

  logic [2:0] hi;
  logic [2:0] lo;
  logic [1:0] idx;

  assign hi = req & ~mask;
  assign lo = req & mask;

  always_comb begin
    win   = 3'b000;
    valid = 1'b0;
    idx   = start;
    for (int k = 0; k < 3; k++) begin
      if (!valid && |(hi & mst_oh(idx))) begin
        win   = mst_oh(idx);
        valid = 1'b1;
      end
      idx = mst_next(idx);
    end
    idx = start;
    for (int k = 0; k < 3; k++) begin
      if (!valid && |(lo & mst_oh(idx))) begin
        win   = mst_oh(idx);
        valid = 1'b1;
      end
      idx = mst_next(idx);
    end
  end

endmodule

// File: rtl/cmsdk_mcu_ahb_arbiter.sv
// Three-master AHB-Lite arbiter (CPU1, CPU2, DMA) for the system bus.
// Re-arbitrates only at transfer boundaries; parks on the last owner.
module cmsdk_mcu_ahb_arbiter
  import cmsdk_mcu_bus_pkg::*;
#(
  parameter int DMA_PRIO  = 0,
  parameter int MAX_BURST = 16
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic [2:0] hbusreq,
  input  logic [2:0] hlock,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic [2:0] hgrant,
  output logic [1:0] hmaster,
  output logic [1:0] hmaster_d,
  output logic       hmastlock
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

  arb_state_t st_q, st_d;
  logic [1:0] own_q, own_d;
  logic [1:0] own_dq;
  logic [7:0] cnt_q, cnt_d;
  logic       lock_q, lock_d;

  logic [2:0] own_oh;
  logic       own_req;
  logic       own_lock;
  logic       others;
  logic       expired;
  logic       rearb;
  logic [1:0] rr_start;
  logic [2:0] rr_mask;
  logic [2:0] rr_win;
  logic       rr_valid;
  logic [1:0] pick;

  assign own_oh   = mst_oh(own_q);
  assign own_req  = |(hbusreq & own_oh);
  assign own_lock = |(hlock & own_oh);
  assign others   = |(hbusreq & ~own_oh);
  assign expired  = (cnt_q == CNT_LAST);

  // BUSY only hands over when the owner has dropped its request
  assign rearb = hready && !own_lock &&
                 (!own_req || htrans == HTRANS_IDLE ||
                  (htrans[1] && expired && others));

  assign rr_start = mst_next(own_q);
  assign rr_mask  = (st_q == ST_OWN && expired) ? own_oh : 3'b000;

  cmsdk_mcu_rr_pick u_pick (
    .req   (hbusreq),
    .start (rr_start),
    .mask  (rr_mask),
    .win   (rr_win),
    .valid (rr_valid)
  );

  always_comb begin
    pick = own_q;
    if (DMA_PRIO != 0 && hbusreq[2]) begin
      pick = MST_DMA;
    end else if (rr_valid) begin
      pick = mst_idx(rr_win);
    end
  end

  always_comb begin
    st_d   = st_q;
    own_d  = own_q;
    cnt_d  = cnt_q;
    lock_d = lock_q;
    if (hready) begin
      unique case (st_q)
        ST_PARK: begin
          if (|hbusreq) begin
            st_d  = ST_OWN;
            own_d = pick;
            cnt_d = 8'd0;
          end
        end
        ST_OWN: begin
          if (htrans[1] && !expired) begin
            cnt_d = cnt_q + 8'd1;
          end
          if (!(|hbusreq)) begin
            st_d  = ST_PARK;
            cnt_d = 8'd0;
          end else if (rearb) begin
            own_d = pick;
            if (pick != own_q || expired) begin
              cnt_d = 8'd0;
            end
          end
        end
        default: st_d = ST_PARK;
      endcase
      lock_d = (own_d == own_q) ? own_lock : 1'b0;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      st_q   <= ST_PARK;
      own_q  <= MST_CPU1;
      own_dq <= MST_CPU1;
      cnt_q  <= 8'd0;
      lock_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      own_q  <= own_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      if (hready) begin
        own_dq <= own_q;
      end
    end
  end

  assign hgrant    = own_oh;
  assign hmaster   = own_q;
  assign hmaster_d = own_dq;
  assign hmastlock = lock_q;

endmodule
